fft_stream_framer: RTL
======================

# fft_stream_framer

Parametrised front/back-end controller for the streaming FFT core: buffers a continuous real-valued ADC sample stream, frames it into Avalon-ST packets of runtime-selectable length (sop/eop/valid/fftpts/inverse) with full sink_ready backpressure, and post-processes the FFT source stream into per-bin power with bin index. It sits between the ADC capture logic and the FFT megafunction instance and replaces fixed-length control generation plus raw real/imag output.

## Interface
Parameters:
- DATA_W, 12, sample width (sink_real/sink_imag)
- OUT_W, 18, FFT source_real/source_imag width
- MAX_LOG2_PTS, 10, largest supported frame = 2^MAX_LOG2_PTS points
- FIFO_DEPTH, 16, input sample FIFO depth (power of 2, ≥4)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  framing enable
- cfg_log2_pts  in  4  frame length exponent, latched at frame start
- cfg_inverse  in  1  inverse-FFT select, latched at frame start
- in_sample  in  DATA_W  signed ADC sample
- in_valid  in  1  sample strobe
- ovf_clear  in  1  clears overflow flag
- sink_valid, sink_sop, sink_eop  out  1 each  FFT sink control
- sink_ready  in  1  FFT sink backpressure
- sink_real  out  DATA_W  sample; sink_imag  out  DATA_W  constant 0
- sink_error  out  2  constant 2'b00
- fftpts  out  MAX_LOG2_PTS+1  current frame length
- inverse  out  1  latched cfg_inverse
- source_valid, source_sop, source_eop  in  1 each  FFT source control
- source_real, source_imag  in  OUT_W  signed FFT outputs
- power  out  2*OUT_W+1  re²+im², unsigned
- power_valid, power_first, power_last  out  1 each
- bin_index  out  MAX_LOG2_PTS  bin number of power
- overflow  out  1  sticky sample-drop flag
- frame_count  out  16  frames fully transferred to sink, wraps

## Operation
- Input FIFO: write on in_valid when not full; in_valid while full drops sample and sets overflow. overflow held until ovf_clear (set wins if same cycle).
- Framer FSM, states IDLE, STREAM:
  - IDLE: when enable=1 and FIFO non-empty, latch n=clamp(cfg_log2_pts,3,MAX_LOG2_PTS), fftpts=1<<n, inverse=cfg_inverse, beat counter=0, go STREAM.
  - STREAM: sink_valid=FIFO non-empty. Beat transfers when sink_valid&&sink_ready; FIFO pops, counter increments. sink_sop=1 on beat 0, sink_eop=1 on beat 2^n−1.
  - On eop transfer: frame_count+1; if enable=1 and FIFO non-empty-after-pop, immediately restart (relatch cfg) staying in STREAM; else IDLE.
- sink_valid/sink_real/sop/eop held stable while sink_valid=1 and sink_ready=0.
- enable deasserted mid-frame: current frame completes; no new frame starts. cfg changes mid-frame ignored.
- fftpts/inverse change only at frame start; stable through frame.
- Power path (independent of framer): on each source_valid beat, stage1 registers source_real², source_imag² (signed square, 2*OUT_W bits); stage2 registers sum into power. bin_index=0 on source_sop beat, else previous+1. power_first/power_last = delayed source_sop/source_eop. source_ready driven 1 externally; no backpressure on this path.

## Timing
- Reset: all outputs 0 (sink_*, fftpts, inverse, power*, bin_index, overflow, frame_count); FIFO empty; FSM IDLE. Reset mid-frame aborts frame with no eop.
- FIFO first-word-fall-through: sample written at edge k earliest on sink_real (sink_valid=1) after edge k+1.
- IDLE→STREAM costs 1 cycle; back-to-back frames have no bubble if FIFO non-empty.
- Power latency: 2 cycles from source_valid beat to power_valid; fully pipelined, one result per cycle.
- Simultaneous FIFO write and pop when full: write accepted (not overflow).
- bin_index wraps naturally at 2^MAX_LOG2_PTS; frame_count wraps 0xFFFF→0.

## Test plan
- cfg_log2_pts=3, sink_ready=1, samples 1..16 continuous -> two 8-beat frames, sop on 1 and 9, eop on 8 and 16, fftpts=8, frame_count=2.
- Same, sink_ready toggling 1/0 every cycle -> identical beat sequence, outputs stable during stalls, no drops.
- sink_ready=0 for 20 cycles, 20 samples in, FIFO_DEPTH=16 -> overflow=1, first 16 samples delivered in order; ovf_clear -> overflow=0.
- cfg_log2_pts changed 3→4 mid-frame -> current frame 8 beats, next fftpts=16; cfg=15 -> clamped to MAX_LOG2_PTS.
- source beats (3,4),(−5,12),(0,0) with sop on first, eop on last -> power 25,169,0, bin_index 0,1,2, 2 cycles later, power_first/last aligned.
- reset_n low mid-frame -> all outputs 0 asynchronously; after release, next frame starts with sop, counter 0.

Source files
------------

// File: rtl/fft_stream_framer_if.sv
// fft_stream_framer_if: bundles every non-clock/reset signal of fft_stream_framer.
//   slave  modport: the framer's view (ADC/cfg/FFT-source inputs; FFT-sink/power outputs).
//   master modport: the environment's view (the opposite directions).
//   Groups: framing control (enable, cfg_log2_pts, cfg_inverse, ovf_clear),
//           ADC stream (in_sample, in_valid),
//           FFT sink (sink_*, fftpts, inverse),
//           FFT source (source_*),
//           power result (power, power_valid/first/last, bin_index),
//           status (overflow, frame_count).
interface fft_stream_framer_if #(
   parameter int DATA_W       = 12,
   parameter int OUT_W        = 18,
   parameter int MAX_LOG2_PTS = 10
);
   logic                      enable;
   logic [3:0]                cfg_log2_pts;
   logic                      cfg_inverse;
   logic signed [DATA_W-1:0]  in_sample;
   logic                      in_valid;
   logic                      ovf_clear;
   logic                      sink_valid;
   logic                      sink_sop;
   logic                      sink_eop;
   logic                      sink_ready;
   logic [DATA_W-1:0]         sink_real;
   logic [DATA_W-1:0]         sink_imag;
   logic [1:0]                sink_error;
   logic [MAX_LOG2_PTS:0]     fftpts;
   logic                      inverse;
   logic                      source_valid;
   logic                      source_sop;
   logic                      source_eop;
   logic signed [OUT_W-1:0]   source_real;
   logic signed [OUT_W-1:0]   source_imag;
   logic [2*OUT_W:0]          power;
   logic                      power_valid;
   logic                      power_first;
   logic                      power_last;
   logic [MAX_LOG2_PTS-1:0]   bin_index;
   logic                      overflow;
   logic [15:0]               frame_count;

   modport slave (
      input  enable, cfg_log2_pts, cfg_inverse, in_sample, in_valid, ovf_clear, sink_ready,
             source_valid, source_sop, source_eop, source_real, source_imag,
      output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, fftpts, inverse,
             power, power_valid, power_first, power_last, bin_index, overflow, frame_count
   );

   modport master (
      output enable, cfg_log2_pts, cfg_inverse, in_sample, in_valid, ovf_clear, sink_ready,
             source_valid, source_sop, source_eop, source_real, source_imag,
      input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, fftpts, inverse,
             power, power_valid, power_first, power_last, bin_index, overflow, frame_count
   );
endinterface

// File: rtl/fft_stream_framer.sv
// fft_stream_framer: buffers an ADC sample stream in a FWFT FIFO, frames it into Avalon-ST
// packets of runtime-selectable length for the FFT sink (full sink_ready backpressure), and
// turns the FFT source stream into per-bin power (re^2 + im^2) with a bin index.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - fft_stream_framer_if.slave (control, ADC stream, FFT sink/source, power, status)
module fft_stream_framer #(
   parameter int DATA_W       = 12,
   parameter int OUT_W        = 18,
   parameter int MAX_LOG2_PTS = 10,
   parameter int FIFO_DEPTH   = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   fft_stream_framer_if.slave  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = MAX_LOG2_PTS + 1;
   localparam int SW = 2 * OUT_W;

   typedef enum logic {StIdle, StStream} state_e;

   // ---------------- input FIFO ----------------
   logic [DATA_W-1:0]       r_mem [FIFO_DEPTH];
   logic [AW:0]             r_wptr, r_wptr_vis, r_rptr;
   logic [AW:0]             w_count, w_vis_count;
   logic                    w_full, w_vis_empty, w_push, w_pop, w_sink_valid;
   logic                    r_ovf;

   // Read side sees writes one cycle late so a sample written at edge k is first presented
   // after edge k+1; the full check uses the true write pointer.
   assign w_count     = r_wptr - r_rptr;
   assign w_vis_count = r_wptr_vis - r_rptr;
   assign w_full      = (w_count == (AW + 1)'(FIFO_DEPTH));
   assign w_vis_empty = (w_vis_count == '0);
   assign w_pop       = w_sink_valid && bus.sink_ready;
   // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
   assign w_push      = bus.in_valid && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.in_sample;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr     <= '0;
         r_wptr_vis <= '0;
         r_rptr     <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_wptr_vis <= r_wptr;
         // Set wins over clear.
         if (bus.in_valid && !w_push) r_ovf <= 1'b1;
         else if (bus.ovf_clear)      r_ovf <= 1'b0;
      end
   end

   // ---------------- framer FSM ----------------
   state_e                  r_state, w_state_d;
   logic [MAX_LOG2_PTS-1:0] r_beat, w_beat_d;
   logic [PW-1:0]           r_fftpts, w_fftpts_d, w_start_pts;
   logic                    r_inverse, w_inverse_d;
   logic [15:0]             r_frame_cnt, w_frame_cnt_d;
   logic [3:0]              w_log2;
   logic                    w_last;

   always_comb begin
      w_log2 = bus.cfg_log2_pts;
      if (bus.cfg_log2_pts < 4'd3)                      w_log2 = 4'd3;
      else if (bus.cfg_log2_pts > 4'(MAX_LOG2_PTS))     w_log2 = 4'(MAX_LOG2_PTS);
   end

   assign w_start_pts  = PW'(1) << w_log2;
   assign w_last       = ({1'b0, r_beat} == (r_fftpts - 1'b1));
   assign w_sink_valid = (r_state == StStream) && !w_vis_empty;

   always_comb begin
      w_state_d     = r_state;
      w_beat_d      = r_beat;
      w_fftpts_d    = r_fftpts;
      w_inverse_d   = r_inverse;
      w_frame_cnt_d = r_frame_cnt;
      case (r_state)
         StIdle: begin
            if (bus.enable && !w_vis_empty) begin
               w_fftpts_d  = w_start_pts;
               w_inverse_d = bus.cfg_inverse;
               w_beat_d    = '0;
               w_state_d   = StStream;
            end
         end
         StStream: begin
            if (w_pop) begin
               if (w_last) begin
                  w_frame_cnt_d = r_frame_cnt + 16'd1;
                  w_beat_d      = '0;
                  // Back-to-back restart only if a sample remains visible after this pop.
                  if (bus.enable && (w_vis_count > (AW + 1)'(1))) begin
                     w_fftpts_d  = w_start_pts;
                     w_inverse_d = bus.cfg_inverse;
                  end else begin
                     w_state_d = StIdle;
                  end
               end else begin
                  w_beat_d = r_beat + 1'b1;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_beat      <= '0;
         r_fftpts    <= '0;
         r_inverse   <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_beat      <= w_beat_d;
         r_fftpts    <= w_fftpts_d;
         r_inverse   <= w_inverse_d;
         r_frame_cnt <= w_frame_cnt_d;
      end
   end

   assign bus.sink_valid  = w_sink_valid;
   assign bus.sink_sop    = w_sink_valid && (r_beat == '0);
   assign bus.sink_eop    = w_sink_valid && w_last;
   assign bus.sink_real   = w_sink_valid ? r_mem[r_rptr[AW-1:0]] : '0;
   assign bus.sink_imag   = '0;
   assign bus.sink_error  = 2'b00;
   assign bus.fftpts      = r_fftpts;
   assign bus.inverse     = r_inverse;
   assign bus.overflow    = r_ovf;
   assign bus.frame_count = r_frame_cnt;

   // ---------------- power path ----------------
   logic signed [SW-1:0]    w_re_ext, w_im_ext;
   logic [SW-1:0]           r_re_sq, r_im_sq;
   logic                    r_v1, r_sop1, r_eop1;
   logic [MAX_LOG2_PTS-1:0] r_bin1, r_bin_next, r_bin_index;
   logic [SW:0]             r_power;
   logic                    r_pvalid, r_pfirst, r_plast;

   assign w_re_ext = SW'(bus.source_real);
   assign w_im_ext = SW'(bus.source_imag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_re_sq     <= '0;
         r_im_sq     <= '0;
         r_v1        <= 1'b0;
         r_sop1      <= 1'b0;
         r_eop1      <= 1'b0;
         r_bin1      <= '0;
         r_bin_next  <= '0;
         r_power     <= '0;
         r_pvalid    <= 1'b0;
         r_pfirst    <= 1'b0;
         r_plast     <= 1'b0;
         r_bin_index <= '0;
      end else begin
         r_v1   <= bus.source_valid;
         r_sop1 <= bus.source_valid && bus.source_sop;
         r_eop1 <= bus.source_valid && bus.source_eop;
         if (bus.source_valid) begin
            r_re_sq    <= w_re_ext * w_re_ext;
            r_im_sq    <= w_im_ext * w_im_ext;
            r_bin1     <= bus.source_sop ? '0 : r_bin_next;
            r_bin_next <= bus.source_sop ? MAX_LOG2_PTS'(1) : r_bin_next + 1'b1;
         end
         r_pvalid <= r_v1;
         r_pfirst <= r_sop1;
         r_plast  <= r_eop1;
         if (r_v1) begin
            r_power     <= {1'b0, r_re_sq} + {1'b0, r_im_sq};
            r_bin_index <= r_bin1;
         end
      end
   end

   assign bus.power       = r_power;
   assign bus.power_valid = r_pvalid;
   assign bus.power_first = r_pfirst;
   assign bus.power_last  = r_plast;
   assign bus.bin_index   = r_bin_index;
endmodule
